// File: rtl/tmc_spi_pkg.sv
// Shared constants, FSM state type and helpers for the SPI register slave.
package tmc_spi_pkg;

    localparam int FRAME_BITS = 16;
    localparam int NUM_RW_REGS = 6;
    localparam logic [6:0] ADDR_STATUS = 7'd6;
    localparam logic [6:0] ADDR_ERRCNT = 7'd7;
    localparam logic [4:0] CNT_SAT = 5'd17;

    typedef enum logic [1:0] {
        WAIT_SS,
        IDLE,
        SHIFT
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/tmc_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input with
// single-cycle rise/fall pulses on the synchronized level.
module tmc_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= {STAGES{RESET_VAL}};
            prev <= RESET_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            prev <= sync[STAGES-1];
        end
    end

    assign level = sync[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/tmc_spi_regslave.sv
// SPI mode-0 register slave: 16-bit frames, six RW registers,
// read-only status and frame-error counter.
module tmc_spi_regslave
    import tmc_spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] REG_RESET   = 8'h00
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        spi_sclk_i,
    input  logic        spi_mosi_i,
    input  logic        spi_ss_n_i,
    output logic        spi_miso_o,
    output logic        spi_miso_oe,
    input  logic [7:0]  status_i,
    output logic [47:0] reg_o,
    output logic        wr_stb_o,
    output logic [2:0]  wr_addr_o,
    output logic [7:0]  wr_data_o,
    output logic [7:0]  err_cnt_o
);

    state_t state, state_nxt;

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic ss_lvl, ss_rise, ss_fall;

    logic [SYNC_STAGES:0] flush;
    logic                 settled;

    logic [4:0]  bit_cnt;
    logic [15:0] shreg;
    logic        rd_frame;
    logic [7:0]  rd_data;
    logic [7:0]  hdr;
    logic [7:0]  rd_sel;
    logic        do_write;
    logic        unused_edges;

    tmc_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
        .clk  (clk_clk),
        .rst  (reset_reset),
        .d    (spi_sclk_i),
        .level(sclk_lvl),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    tmc_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi (
        .clk  (clk_clk),
        .rst  (reset_reset),
        .d    (spi_mosi_i),
        .level(mosi_lvl),
        .rise (mosi_rise),
        .fall (mosi_fall)
    );

    tmc_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss (
        .clk  (clk_clk),
        .rst  (reset_reset),
        .d    (spi_ss_n_i),
        .level(ss_lvl),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    assign unused_edges = &{sclk_lvl, mosi_rise, mosi_fall};

    // The reset value of the ss_n synchronizer must drain before WAIT_SS
    // trusts the level, otherwise a frame cut by reset would look new.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            flush <= '0;
        end else begin
            flush <= {flush[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign settled = flush[SYNC_STAGES];

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state <= WAIT_SS;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT_SS: if (settled && ss_lvl) state_nxt = IDLE;
            IDLE:    if (ss_fall) state_nxt = SHIFT;
            SHIFT:   if (ss_rise) state_nxt = IDLE;
            default: state_nxt = WAIT_SS;
        endcase
    end

    assign spi_miso_oe = (state == SHIFT);

    // Header as it will look once the 8th bit lands in the shift register.
    assign hdr = {shreg[6:0], mosi_lvl};

    always_comb begin
        rd_sel = 8'h00;
        for (int i = 0; i < NUM_RW_REGS; i++) begin
            if (hdr[6:0] == 7'(i)) rd_sel = reg_o[8*i +: 8];
        end
        if (hdr[6:0] == ADDR_STATUS) rd_sel = status_i;
        if (hdr[6:0] == ADDR_ERRCNT) rd_sel = err_cnt_o;
    end

    assign do_write = !shreg[15] && (shreg[14:8] < 7'(NUM_RW_REGS));

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            rd_frame   <= 1'b0;
            rd_data    <= '0;
            reg_o      <= {NUM_RW_REGS{REG_RESET}};
            err_cnt_o  <= '0;
            wr_stb_o   <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
            spi_miso_o <= 1'b0;
        end else begin
            wr_stb_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    spi_miso_o <= 1'b0;
                    if (ss_fall) begin
                        bit_cnt  <= '0;
                        shreg    <= '0;
                        rd_frame <= 1'b0;
                        rd_data  <= '0;
                    end
                end
                SHIFT: begin
                    if (ss_rise) begin
                        spi_miso_o <= 1'b0;
                        if (bit_cnt == 5'(FRAME_BITS)) begin
                            if (do_write) begin
                                wr_stb_o  <= 1'b1;
                                wr_addr_o <= shreg[10:8];
                                wr_data_o <= shreg[7:0];
                                for (int i = 0; i < NUM_RW_REGS; i++) begin
                                    if (shreg[14:8] == 7'(i))
                                        reg_o[8*i +: 8] <= shreg[7:0];
                                end
                            end
                        end else begin
                            err_cnt_o <= sat_inc8(err_cnt_o);
                        end
                    end else begin
                        if (sclk_rise) begin
                            shreg <= {shreg[14:0], mosi_lvl};
                            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                rd_frame <= hdr[7];
                                rd_data  <= rd_sel;
                            end
                        end
                        // Falling edges 8..15 carry data bits 7..0.
                        if (sclk_fall) begin
                            if (rd_frame && bit_cnt[4:3] == 2'b01)
                                spi_miso_o <= rd_data[~bit_cnt[2:0]];
                            else
                                spi_miso_o <= 1'b0;
                        end
                    end
                end
                default: spi_miso_o <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_tmc_spi_regslave.sv
// Directed and randomized frames against a frame-level model of the
// register slave; results are checked with immediate assertions.
module tb_tmc_spi_regslave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        ss_n = 1'b1;
    logic        miso;
    logic        miso_oe;
    logic [7:0]  status = 8'h00;
    logic [47:0] regs_q;
    logic        wr_stb;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    tmc_spi_regslave #(.SYNC_STAGES(2), .REG_RESET(8'h00)) dut (
        .clk_clk    (clk),
        .reset_reset(rst),
        .spi_sclk_i (sclk),
        .spi_mosi_i (mosi),
        .spi_ss_n_i (ss_n),
        .spi_miso_o (miso),
        .spi_miso_oe(miso_oe),
        .status_i   (status),
        .reg_o      (regs_q),
        .wr_stb_o   (wr_stb),
        .wr_addr_o  (wr_addr),
        .wr_data_o  (wr_data),
        .err_cnt_o  (err_cnt)
    );

    int n_checks = 0;
    int n_fail = 0;

    int          stb_pulses = 0;
    int          stb_cycles = 0;
    logic        stb_prev = 1'b0;
    logic [2:0]  stb_addr;
    logic [7:0]  stb_data;
    logic [47:0] stb_regs;

    always @(negedge clk) begin
        if (wr_stb) begin
            stb_cycles++;
            if (!stb_prev) stb_pulses++;
            stb_addr = wr_addr;
            stb_data = wr_data;
            stb_regs = regs_q;
        end
        stb_prev = wr_stb;
    end

    logic [7:0] m_regs [6];
    logic [7:0] m_err;
    logic [2:0] m_waddr;
    logic [7:0] m_wdata;

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_regs[i] = 8'h00;
        m_err = 8'h00;
        m_waddr = 3'd0;
        m_wdata = 8'h00;
    endtask

    function automatic logic [47:0] model_vec();
        logic [47:0] v;
        for (int i = 0; i < 6; i++) v[8*i +: 8] = m_regs[i];
        return v;
    endfunction

    task automatic check(input string tag, input logic [47:0] obs,
                         input logic [47:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame of nbits (MSB first from word); rst_after >= 0
    // pulses reset just before that bit index is sent.
    task automatic do_frame(input int nbits, input logic [16:0] word,
                            input int rst_after);
        int          p0, c0;
        logic [15:0] rx;
        logic        rw, exp_stb, aborted;
        logic [6:0]  addr;
        logic [7:0]  data, exp_rd;
        p0 = stb_pulses;
        c0 = stb_cycles;
        rx = '0;
        rw = word[15];
        addr = word[14:8];
        data = word[7:0];
        aborted = (rst_after >= 0);
        exp_rd = 8'h00;
        if (addr < 7'd6) exp_rd = m_regs[addr];
        else if (addr == 7'd6) exp_rd = status;
        else if (addr == 7'd7) exp_rd = m_err;
        ss_n = 1'b0;
        tick(8);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_after) begin
                rst = 1'b1;
                tick(2);
                rst = 1'b0;
                model_reset();
            end
            mosi = word[nbits-1-i];
            tick(8);
            rx = {rx[14:0], miso};
            sclk = 1'b1;
            if (i == 0) check("oe_in_frame", 48'(miso_oe), 48'd1);
            tick(8);
            sclk = 1'b0;
        end
        tick(8);
        ss_n = 1'b1;
        tick(16);
        exp_stb = 1'b0;
        if (!aborted) begin
            if (nbits != 16) begin
                if (m_err != 8'hFF) m_err = m_err + 8'd1;
            end else if (!rw && addr < 7'd6) begin
                exp_stb = 1'b1;
                m_regs[addr] = data;
                m_waddr = addr[2:0];
                m_wdata = data;
            end
        end
        check("oe_after", 48'(miso_oe), 48'd0);
        check("stb_pulses", 48'(stb_pulses - p0), 48'(exp_stb));
        check("stb_cycles", 48'(stb_cycles - c0), 48'(exp_stb));
        if (exp_stb) begin
            check("stb_addr", 48'(stb_addr), 48'(m_waddr));
            check("stb_data", 48'(stb_data), 48'(m_wdata));
            check("stb_regs", stb_regs, model_vec());
        end
        check("wr_addr_hold", 48'(wr_addr), 48'(m_waddr));
        check("wr_data_hold", 48'(wr_data), 48'(m_wdata));
        check("reg_o", regs_q, model_vec());
        check("err_cnt", 48'(err_cnt), 48'(m_err));
        if (nbits == 16 && !aborted)
            check("miso", 48'(rx), rw ? 48'({8'h00, exp_rd}) : 48'd0);
    endtask

    initial begin
        int          nb, r;
        logic        rw;
        logic [6:0]  a;
        logic [7:0]  d;
        model_reset();
        tick(4);
        check("rst_reg_o", regs_q, 48'd0);
        check("rst_err", 48'(err_cnt), 48'd0);
        check("rst_stb", 48'(wr_stb), 48'd0);
        check("rst_addr", 48'(wr_addr), 48'd0);
        check("rst_data", 48'(wr_data), 48'd0);
        check("rst_miso", {46'd0, miso, miso_oe}, 48'd0);
        rst = 1'b0;
        tick(10);

        do_frame(16, 17'h003A5, -1);
        check("reg3_a5", 48'(regs_q[31:24]), 48'hA5);
        do_frame(16, 17'h08300, -1);

        status = 8'h5C;
        do_frame(16, 17'h08600, -1);
        do_frame(16, 17'h0C000, -1);
        do_frame(16, 17'h006FF, -1);

        do_frame(15, 17'h00123, -1);
        do_frame(17, 17'h00246, -1);
        check("err_two", 48'(err_cnt), 48'd2);
        for (int k = 0; k < 300; k++) do_frame(1, 17'h1, -1);
        check("err_sat", 48'(err_cnt), 48'hFF);
        do_frame(16, 17'h08700, -1);

        do_frame(16, 17'h00111, 10);
        check("rst_mid_err", 48'(err_cnt), 48'd0);
        do_frame(16, 17'h00122, -1);
        check("reg1_22", 48'(regs_q[15:8]), 48'h22);

        for (int k = 0; k < 30; k++) begin
            r = $urandom_range(0, 9);
            nb = (r == 0) ? 15 : (r == 1) ? 17 : 16;
            rw = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                            : 7'($urandom_range(0, 7));
            d = 8'($urandom);
            status = 8'($urandom);
            do_frame(nb, {1'b0, rw, a, d}, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tmc_spi_regslave.md
TMC_SPI_REGSLAVE -- requirements
Module: tmc_spi_regslave

Interface
REQ-001 The block SHALL have these parameters:
- SYNC_STAGES, 2, synchronizer depth on spi_* inputs (≥2).
- REG_RESET, 8'h00, reset value of each RW register.
REQ-002 The block SHALL have these ports, in order:
- clk_clk  in  1  system clock; the only clock.
- reset_reset  in  1  reset, synchronous, active-high.
- spi_sclk_i  in  1  SPI clock from spi_0 master; asynchronous.
- spi_mosi_i  in  1  master-out data; asynchronous.
- spi_ss_n_i  in  1  one bit of spi_0 SS_n, active-low; asynchronous.
- spi_miso_o  out  1  slave-out data.
- spi_miso_oe  out  1  MISO output enable.
- status_i  in  8  read-only status word.
- reg_o  out  48  RW registers 0..5, reg0 in bits 7:0.
- wr_stb_o  out  1  one-cycle pulse per committed write.
- wr_addr_o  out  3  address of committed write.
- wr_data_o  out  8  data of committed write.
- err_cnt_o  out  8  frame error counter.

Function
REQ-003 SPI mode 0 (CPOL=0, CPHA=0), MSB first; clk_clk SHALL be ≥16× SCLK.
REQ-004 Frame = 16 bits: bit15 R/W (1=read), bits14:8 address, bits7:0 data.
REQ-005 All three spi_* inputs SHALL pass a SYNC_STAGES flop synchronizer, then a 1-cycle edge detector.
REQ-006 FSM states: WAIT_SS, IDLE, SHIFT.
- WAIT_SS -> IDLE when synced ss_n = 1.
- IDLE -> SHIFT on synced ss_n falling edge; clears bit counter (5 bits) and shift register.
- SHIFT: each SCLK rising edge shifts MOSI into the shift register and increments the bit counter (saturates at 17).
- SHIFT -> IDLE on synced ss_n rising edge.
REQ-007 Address map: 0..5 RW registers, 6 = status_i (RO), 7 = err_cnt (RO), 8..127 unmapped.
REQ-008 Read: the read value SHALL be captured when the bit counter reaches 8.
- Captured value = register, status_i, err_cnt or 8'h00 (unmapped).
- It SHALL be shifted out MSB first, one bit per SCLK falling edge, starting at the 8th falling edge.
- spi_miso_o SHALL update ≤2 clk_clk cycles after that falling edge is detected.
REQ-009 spi_miso_o SHALL be 0 during bits 15:8 of every frame and during the entire data phase of write frames.
REQ-010 spi_miso_oe SHALL be 1 exactly while FSM = SHIFT.
REQ-011 Commit: on ss_n rise with bit counter = 16, a write frame to addr 0..5 SHALL, in the following cycle:
- assert wr_stb_o for 1 cycle;
- drive wr_addr_o/wr_data_o;
- update reg_o (new value visible in the same cycle as wr_stb_o).
REQ-012 Writes to addr 6..127 SHALL be discarded without wr_stb_o; read frames never produce wr_stb_o.
REQ-013 A frame ending with bit counter ≠16 (short or long) SHALL be discarded and increment err_cnt_o; err_cnt_o saturates at 8'hFF.
REQ-014 SCLK edges while FSM ≠ SHIFT SHALL be ignored.
REQ-015 wr_addr_o/wr_data_o SHALL hold their last committed values between strobes.

Reset
REQ-016 On reset_reset, with no other effect, the block SHALL set:
- FSM = WAIT_SS;
- reg_o = {6{REG_RESET}};
- err_cnt_o, wr_stb_o, wr_addr_o, wr_data_o, spi_miso_o, spi_miso_oe = 0;
- synchronizer flops: ss_n = 1, others = 0.
REQ-017 Reset asserted mid-frame SHALL abort the frame, commit nothing and count no error; the remainder of that frame is ignored via WAIT_SS.

Structure
REQ-018 Package tmc_spi_pkg SHALL hold:
- FRAME_BITS=16;
- address constants ADDR_STATUS=6 and ADDR_ERRCNT=7;
- NUM_RW_REGS=6;
- the FSM state enum.
REQ-019 Sub-module tmc_sync_edge (synchronizer + rise/fall pulse outputs) SHALL be instantiated once per spi_* input.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Write 0x03A5 at SCLK=clk/16 -> one wr_stb_o, wr_addr_o=3, wr_data_o=A5, reg_o[31:24]=A5.
- Read frame 0x8300 after the previous write -> MISO bits 7:0 = A5; no wr_stb_o.
- status_i=5C, read addr 6 -> 5C; read addr 0x40 -> 00; write addr 6 -> no strobe, reg_o unchanged.
- Frames of 15 and 17 bits -> no commit, err_cnt_o 0->2; 300 short frames -> err_cnt_o=FF, read addr 7 returns FF.
- reset_reset pulsed after bit 10 of write 0x0111 -> no strobe, err_cnt_o=0; next valid write 0x0122 commits reg1=22.
